arbiter_dwrr_beat: RTL and testbench

ARBITER_DWRR_BEAT -- requirements
Module: arbiter_dwrr_beat

---
 rtl/axi_icn_arb_pkg.sv | 12 +
 rtl/rr_prio_search.sv | 31 +++
 rtl/arbiter_dwrr_beat.sv | 136 +++++++++++++
 tb/tb_arbiter_dwrr_beat.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/axi_icn_arb_pkg.sv
// Shared arbiter encodings: FSM states and the default per-requester beat quantum.
package axi_icn_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Element 0 (requester 0) sits in the leftmost 32 bits.
  localparam logic [0:95] DEFAULT_WEIGHTS = {32'd5, 32'd3, 32'd2};

endpackage

// File: rtl/rr_prio_search.sv
// Circular first-set search: lowest set index of vec_i at or after ptr_i, wrapping.
module rr_prio_search #(
  parameter int P_N    = 3,
  parameter int P_ID_W = 2
) (
  input  logic [P_N-1:0]    vec_i,
  input  logic [P_ID_W-1:0] ptr_i,
  output logic              found_o,
  output logic [P_ID_W-1:0] idx_o
);

  int              j;
  logic [P_ID_W-1:0] pos;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    pos     = '0;
    for (int k = 0; k < P_N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= P_N) j = j - P_N;
      pos = P_ID_W'(j);
      if (!found_o && vec_i[pos]) begin
        found_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

endmodule

// File: rtl/arbiter_dwrr_beat.sv
// Beat-weighted deficit round-robin arbiter; grant registered one cycle after a winning decision.
// A grant is held until grant_ready_i, then one idle bubble before the next decision.
module arbiter_dwrr_beat
  import axi_icn_arb_pkg::*;
#(
  parameter int                             P_REQUESTER_NUM    = 3,
  parameter logic [0:P_REQUESTER_NUM*32-1]  P_REQUESTER_WEIGHT = DEFAULT_WEIGHTS,
  parameter int                             P_COST_W           = 4,
  parameter int                             P_CREDIT_W         = 8,
  localparam int                            ID_W = (P_REQUESTER_NUM > 1) ? $clog2(P_REQUESTER_NUM) : 1
) (
  input  logic                                ACLK_i,
  input  logic                                ARESET_i,
  input  logic [P_REQUESTER_NUM-1:0]          req_i,
  input  logic [P_COST_W*P_REQUESTER_NUM-1:0] cost_i,
  input  logic                                grant_ready_i,
  output logic [P_REQUESTER_NUM-1:0]          grant_valid_o,
  output logic [ID_W-1:0]                     grant_id_o,
  output logic [P_COST_W-1:0]                 grant_cost_o
);

  logic [P_CREDIT_W-1:0] weight_eff [P_REQUESTER_NUM];
  logic [P_COST_W-1:0]   cost_eff   [P_REQUESTER_NUM];

  if (P_COST_W > P_CREDIT_W) begin : g_cost_chk
    $error("largest beat cost does not fit in a credit counter");
  end

  for (genvar i = 0; i < P_REQUESTER_NUM; i++) begin : g_req
    localparam logic [31:0] W_RAW = P_REQUESTER_WEIGHT[i*32 +: 32];
    if (64'(W_RAW) > ((64'd1 << P_CREDIT_W) - 64'd1)) begin : g_w_chk
      $error("requester weight does not fit in a credit counter");
    end
    // Zero weight or zero cost would stall the rotation, so both floor at 1.
    assign weight_eff[i] = (W_RAW == 32'd0) ? P_CREDIT_W'(1) : W_RAW[P_CREDIT_W-1:0];
    assign cost_eff[i]   = (cost_i[P_COST_W*(i+1)-1 -: P_COST_W] == '0) ? P_COST_W'(1)
                                                                       : cost_i[P_COST_W*(i+1)-1 -: P_COST_W];
  end

  arb_state_e            state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  refilled_q, refilled_d;
  logic [P_CREDIT_W-1:0] credit_q [P_REQUESTER_NUM];
  logic [P_CREDIT_W-1:0] credit_d [P_REQUESTER_NUM];
  logic [ID_W-1:0]       grant_id_q, grant_id_d;
  logic [P_COST_W-1:0]   grant_cost_q, grant_cost_d;

  logic                  found;
  logic [ID_W-1:0]       cand;
  logic [ID_W-1:0]       cand_next;
  logic [P_CREDIT_W:0]   sum;
  logic [P_CREDIT_W-1:0] eff;
  logic [P_CREDIT_W-1:0] cost_ext;

  rr_prio_search #(
    .P_N    (P_REQUESTER_NUM),
    .P_ID_W (ID_W)
  ) u_search (
    .vec_i   (req_i),
    .ptr_i   (ptr_q),
    .found_o (found),
    .idx_o   (cand)
  );

  always_comb begin
    sum       = {1'b0, credit_q[cand]} + {1'b0, weight_eff[cand]};
    cost_ext  = P_CREDIT_W'(cost_eff[cand]);
    cand_next = (cand == ID_W'(P_REQUESTER_NUM - 1)) ? '0 : cand + ID_W'(1);
    // The requester that just won keeps drawing on its banked credit until it runs short.
    if (refilled_q && (cand == ptr_q)) eff = credit_q[cand];
    else if (sum[P_CREDIT_W])          eff = '1;
    else                               eff = sum[P_CREDIT_W-1:0];
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    refilled_d   = refilled_q;
    grant_id_d   = grant_id_q;
    grant_cost_d = grant_cost_q;
    for (int i = 0; i < P_REQUESTER_NUM; i++) begin
      credit_d[i] = credit_q[i];
      if (!req_i[i] && !((state_q == ST_GRANT) && (grant_id_q == ID_W'(i))))
        credit_d[i] = '0;
    end
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          if (eff >= cost_ext) begin
            credit_d[cand] = eff - cost_ext;
            ptr_d          = cand;
            refilled_d     = 1'b1;
            grant_id_d     = cand;
            grant_cost_d   = cost_eff[cand];
            state_d        = ST_GRANT;
          end else begin
            credit_d[cand] = eff;
            ptr_d          = cand_next;
            refilled_d     = 1'b0;
          end
        end
      end
      ST_GRANT: begin
        if (grant_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      refilled_q   <= 1'b0;
      grant_id_q   <= '0;
      grant_cost_q <= '0;
      for (int i = 0; i < P_REQUESTER_NUM; i++) credit_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      refilled_q   <= refilled_d;
      grant_id_q   <= grant_id_d;
      grant_cost_q <= grant_cost_d;
      for (int i = 0; i < P_REQUESTER_NUM; i++) credit_q[i] <= credit_d[i];
    end
  end

  always_comb begin
    grant_valid_o = '0;
    if (state_q == ST_GRANT) grant_valid_o[grant_id_q] = 1'b1;
  end

  assign grant_id_o   = grant_id_q;
  assign grant_cost_o = grant_cost_q;

endmodule

// File: tb/tb_arbiter_dwrr_beat.sv
// Directed bench for arbiter_dwrr_beat with default weights 5/3/2.
module tb_arbiter_dwrr_beat;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [2:0]  req = '0;
  logic [11:0] cost = '0;
  logic        rdy = 1'b0;
  logic [2:0]  gvld;
  logic [1:0]  gid;
  logic [3:0]  gcost;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arbiter_dwrr_beat dut (
    .ACLK_i        (clk),
    .ARESET_i      (arst),
    .req_i         (req),
    .cost_i        (cost),
    .grant_ready_i (rdy),
    .grant_valid_o (gvld),
    .grant_id_o    (gid),
    .grant_cost_o  (gcost)
  );

  typedef struct {
    logic [2:0]  req;
    logic [11:0] cost;
    logic        rdy;
    logic [2:0]  exp_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    arst = 1'b1; req = '0; cost = '0; rdy = 1'b0;
    tick();
    tick();
    arst = 1'b0;
  endtask

  task automatic add(input logic [2:0] e);
    vecs.push_back('{3'b111, 12'h111, 1'b1, e});
  endtask

  initial begin
    int   ids[4];
    int   ng;
    logic [2:0] tog[5];
    logic [1:0] eid;

    // Weight 5/3/2 at cost 1: five grants to 0, three to 1, two to 2, with an
    // extra idle cycle each time a requester runs out of credit.
    for (int k = 0; k < 5; k++) begin add(3'b001); add(3'b000); end
    add(3'b000);
    for (int k = 0; k < 3; k++) begin add(3'b010); add(3'b000); end
    add(3'b000);
    for (int k = 0; k < 2; k++) begin add(3'b100); add(3'b000); end
    add(3'b000);
    add(3'b001);

    do_reset();
    chk("rst_vld", 32'(gvld), 0);
    chk("rst_id", 32'(gid), 0);
    chk("rst_cost", 32'(gcost), 0);
    chk("rst_credit0", 32'(dut.credit_q[0]), 0);

    foreach (vecs[k]) begin
      req = vecs[k].req; cost = vecs[k].cost; rdy = vecs[k].rdy;
      tick();
      chk($sformatf("seq_vld[%0d]", k), 32'(gvld), 32'(vecs[k].exp_vld));
      if (vecs[k].exp_vld != 3'b000) begin
        eid = vecs[k].exp_vld[2] ? 2'd2 : (vecs[k].exp_vld[1] ? 2'd1 : 2'd0);
        chk($sformatf("seq_id[%0d]", k), 32'(gid), 32'(eid));
        chk($sformatf("seq_cost[%0d]", k), 32'(gcost), 1);
      end
    end

    // Cost 4 everywhere: grants 0,0,1,2 and credits 2,2,0 right after the fourth.
    do_reset();
    req = 3'b111; cost = 12'h444; rdy = 1'b1;
    ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      tick();
      if (gvld != 3'b000) begin
        ids[ng] = int'(gid);
        ng++;
      end
    end
    chk("cost4_grants", 32'(ng), 4);
    if (ng == 4) begin
      chk("cost4_id0", 32'(ids[0]), 0);
      chk("cost4_id1", 32'(ids[1]), 0);
      chk("cost4_id2", 32'(ids[2]), 1);
      chk("cost4_id3", 32'(ids[3]), 2);
      chk("cost4_credit0", 32'(dut.credit_q[0]), 2);
      chk("cost4_credit1", 32'(dut.credit_q[1]), 2);
      chk("cost4_credit2", 32'(dut.credit_q[2]), 0);
    end

    // Lone requester 1 with cost 8 and weight 3 needs three decisions.
    do_reset();
    req = 3'b010; cost = 12'h080; rdy = 1'b0;
    tick();
    chk("lone_vld_e1", 32'(gvld), 0);
    tick();
    chk("lone_vld_e2", 32'(gvld), 0);
    chk("lone_credit_e2", 32'(dut.credit_q[1]), 6);
    tick();
    chk("lone_vld_e3", 32'(gvld), 32'(3'b010));
    chk("lone_cost", 32'(gcost), 8);
    chk("lone_credit", 32'(dut.credit_q[1]), 1);

    // Grant held through five stalled cycles while inputs churn.
    tog = '{3'b101, 3'b000, 3'b111, 3'b001, 3'b100};
    for (int k = 0; k < 5; k++) begin
      req = tog[k]; cost = 12'($urandom); rdy = 1'b0;
      tick();
      chk($sformatf("hold_vld[%0d]", k), 32'(gvld), 32'(3'b010));
      chk($sformatf("hold_id[%0d]", k), 32'(gid), 1);
      chk($sformatf("hold_cost[%0d]", k), 32'(gcost), 8);
    end
    chk("hold_credit1", 32'(dut.credit_q[1]), 1);
    req = 3'b000; rdy = 1'b1;
    tick();
    chk("hold_release_vld", 32'(gvld), 0);

    // Reset during a grant to requester 1.
    do_reset();
    req = 3'b010; cost = 12'h111; rdy = 1'b0;
    tick();
    chk("mid_grant_vld", 32'(gvld), 32'(3'b010));
    arst = 1'b1; req = 3'b111; rdy = 1'b1;
    tick();
    chk("mid_rst_vld", 32'(gvld), 0);
    chk("mid_rst_id", 32'(gid), 0);
    chk("mid_rst_cost", 32'(gcost), 0);
    chk("mid_rst_credit1", 32'(dut.credit_q[1]), 0);
    arst = 1'b0;
    tick();
    chk("post_rst_vld", 32'(gvld), 32'(3'b001));
    chk("post_rst_id", 32'(gid), 0);

    // Idle requester loses banked credit; zero cost debits one beat.
    do_reset();
    req = 3'b100; cost = 12'h400; rdy = 1'b0;
    tick();
    chk("bank_credit2", 32'(dut.credit_q[2]), 2);
    chk("bank_vld", 32'(gvld), 0);
    req = 3'b000;
    tick();
    chk("drop_credit2", 32'(dut.credit_q[2]), 0);
    req = 3'b100; cost = 12'h000;
    tick();
    chk("zero_cost_vld", 32'(gvld), 32'(3'b100));
    chk("zero_cost_credit2", 32'(dut.credit_q[2]), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
